// File: rtl/cmb_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cmb_sched_pkg
// Purpose  : Shared types and constants for the evaluator scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package cmb_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DATA_W = 16;
    localparam int RES_W  = 4;

    // Width needed to hold the latency countdown value EVAL_LAT.
    function automatic int cnt_width(input int eval_lat);
        return (eval_lat < 1) ? 1 : $clog2(eval_lat + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmb_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : cmb_rr_arb
// Purpose  : Combinational round-robin selector; search starts at ptr, wraps.
// Revision : 1.0 - initial release
// ============================================================================
module cmb_rr_arb #(
    parameter int NREQ  = 4,
    parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [PTR_W-1:0] gnt_idx
);

    logic w_found;
    int   w_idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = int'(ptr) + i;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (!w_found && req[w_idx]) begin
                w_found    = 1'b1;
                gnt[w_idx] = 1'b1;
                gnt_idx    = PTR_W'(w_idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cmb_sched.sv
`default_nettype none
// ============================================================================
// Module   : cmb_sched
// Purpose  : Shares one external evaluator between NREQ requesters, one
//            transaction at a time, with round-robin arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module cmb_sched
    import cmb_sched_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int EVAL_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [RES_W-1:0]       rsp_data,
    input  logic [NREQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]      eval_in,
    input  logic [RES_W-1:0]       eval_out,
    output logic                   busy
);

    localparam int c_PTR_W = $clog2(NREQ);
    localparam int c_CNT_W = cnt_width(EVAL_LAT);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_PTR_W-1:0]   r_ptr;
    logic [c_PTR_W-1:0]   r_owner;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]    r_eval_in;
    logic [RES_W-1:0]     r_result;

    logic [NREQ-1:0]      w_gnt;
    logic [c_PTR_W-1:0]   w_gnt_idx;
    logic                 w_accept;
    logic                 w_cnt_last;

    cmb_rr_arb #(
        .NREQ  (NREQ),
        .PTR_W (c_PTR_W)
    ) u_arb (
        .req     (req_valid),
        .ptr     (r_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // req_ready is gated by rst_n so it drops the instant reset asserts.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_cnt_last  = 1'b0;
        req_ready   = '0;
        rsp_valid   = '0;
        busy        = (r_state != IDLE);
        unique case (r_state)
            IDLE: begin
                if (rst_n && (|req_valid)) begin
                    req_ready   = w_gnt;
                    w_accept    = 1'b1;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == c_CNT_W'(1)) begin
                    w_cnt_last  = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid[r_owner] = 1'b1;
                if (rsp_ready[r_owner]) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr     <= '0;
            r_owner   <= '0;
            r_cnt     <= '0;
            r_eval_in <= '0;
            r_result  <= '0;
        end else if (w_accept) begin
            r_eval_in <= req_data[w_gnt_idx*DATA_W +: DATA_W];
            r_owner   <= w_gnt_idx;
            r_cnt     <= c_CNT_W'(EVAL_LAT);
            r_ptr     <= (w_gnt_idx == c_PTR_W'(NREQ - 1)) ? '0
                                                           : w_gnt_idx + c_PTR_W'(1);
        end else if (r_state == WAIT) begin
            r_cnt <= r_cnt - c_CNT_W'(1);
            if (w_cnt_last) begin
                r_result <= eval_out;
            end
        end
    end

    assign eval_in  = r_eval_in;
    assign rsp_data = r_result;

endmodule
`default_nettype wire

// File: tb/tb_cmb_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmb_sched
// Purpose  : Randomized scoreboard bench for cmb_sched with directed phases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmb_sched;

    localparam int NREQ     = 4;
    localparam int EVAL_LAT = 3;
    localparam int EP_IDX   = (EVAL_LAT > 1) ? EVAL_LAT - 2 : 0;

    logic                 clk       = 1'b0;
    logic                 rst_n     = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ*16-1:0]   req_data  = '0;
    logic [NREQ-1:0]      rsp_ready = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      rsp_valid;
    logic [3:0]           rsp_data;
    logic [15:0]          eval_in;
    logic [3:0]           eval_out;
    logic                 busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Evaluator: eval_out follows eval_in[3:0] through EVAL_LAT-1 register stages.
    logic [3:0] epipe [0:15];
    always @(posedge clk) begin
        epipe[0] <= eval_in[3:0];
        for (int k = 1; k < 16; k++) epipe[k] <= epipe[k-1];
    end
    assign eval_out = (EVAL_LAT == 1) ? eval_in[3:0] : epipe[EP_IDX];

    cmb_sched #(.NREQ(NREQ), .EVAL_LAT(EVAL_LAT)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .eval_in   (eval_in),
        .eval_out  (eval_out),
        .busy      (busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        int         owner;
        logic [3:0] res;
        int         due;
    } exp_t;

    exp_t sbq[$];
    bit   front_seen = 1'b0;
    int   done_cyc   = -20;

    // Transaction-level reference: who wins, what comes back, and when.
    int          m_ptr  = 0;
    bit          m_have = 1'b0;
    int          m_acc  = -10;
    logic [15:0] m_opnd = '0;
    bit          glog_en = 1'b0;
    int          glog_c[$];
    int          glog_g[$];

    always @(negedge clk) begin
        bit              outst;
        logic [NREQ-1:0] exp_rdy;
        int              win;
        if (!rst_n) begin
            m_ptr  = 0;
            m_have = 1'b0;
            sbq.delete();
        end else begin
            outst   = m_have && !(done_cyc > m_acc && done_cyc < cyc);
            exp_rdy = '0;
            win     = -1;
            if (!outst) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (win < 0 && req_valid[(m_ptr + i) % NREQ]) win = (m_ptr + i) % NREQ;
                end
            end
            if (win >= 0) exp_rdy[win] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("busy", 32'(busy), 32'(outst));
            if (outst) chk("eval_in_hold", 32'(eval_in), 32'(m_opnd));
            if (glog_en && req_ready != '0) begin
                glog_c.push_back(cyc);
                glog_g.push_back(int'(req_ready));
            end
            if (win >= 0) begin
                m_opnd = req_data[win*16 +: 16];
                sbq.push_back('{win, m_opnd[3:0], cyc + EVAL_LAT + 1});
                m_ptr  = (win + 1) % NREQ;
                m_have = 1'b1;
                m_acc  = cyc;
            end
        end
    end

    // Response monitor: pops the scoreboard when the owner handshakes.
    always @(negedge clk) begin
        logic [NREQ-1:0] ev;
        if (!rst_n) begin
            front_seen = 1'b0;
        end else if (sbq.size() == 0) begin
            chk("rsp_idle", 32'(rsp_valid), 32'h0);
        end else begin
            ev = '0;
            ev[sbq[0].owner] = 1'b1;
            if (rsp_valid == '0) begin
                if (front_seen || cyc >= sbq[0].due) begin
                    chk(front_seen ? "rsp_hold" : "rsp_late", 32'(rsp_valid), 32'(ev));
                    void'(sbq.pop_front());
                    front_seen = 1'b0;
                    done_cyc   = cyc;
                end
            end else begin
                if (!front_seen) chk("rsp_first_cycle", 32'(cyc), 32'(sbq[0].due));
                front_seen = 1'b1;
                chk("rsp_valid", 32'(rsp_valid), 32'(ev));
                chk("rsp_data", 32'(rsp_data), 32'(sbq[0].res));
                if (rsp_ready[sbq[0].owner]) begin
                    void'(sbq.pop_front());
                    front_seen = 1'b0;
                    done_cyc   = cyc;
                end
            end
        end
    end

    task automatic drive(input logic [NREQ-1:0] rv, input logic [NREQ-1:0] rr, input int n);
        req_valid = rv;
        rsp_ready = rr;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rand_data();
        for (int i = 0; i < NREQ; i++) req_data[i*16 +: 16] = 16'($urandom);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_eval_in", 32'(eval_in), 32'h0);
        chk("rst_rsp_data", 32'(rsp_data), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset held from time zero with every requester asking.
        req_valid = '1;
        rand_data();
        @(posedge clk);
        #2;
        chk("por_req_ready", 32'(req_ready), 32'h0);
        chk("por_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("por_busy", 32'(busy), 32'h0);
        chk("por_eval_in", 32'(eval_in), 32'h0);
        chk("por_rsp_data", 32'(rsp_data), 32'h0);
        @(posedge clk);
        #1;
        req_valid = '0;
        rst_n     = 1'b1;
        drive('0, '0, 2);

        // Single request from requester 2.
        req_data[2*16 +: 16] = 16'hABC5;
        drive(4'b0100, 4'b0100, 1);
        drive(4'b0000, 4'b0100, EVAL_LAT + 4);

        // Reset while in WAIT, with ptr pointing away from requester 0.
        rand_data();
        drive(4'b0100, 4'b0000, 1);
        req_valid = '0;
        pulse_reset();

        // Round-robin with everyone valid and responses always consumed.
        glog_en = 1'b1;
        drive(4'b1111, 4'b1111, 5 * (EVAL_LAT + 2) + 1);
        glog_en = 1'b0;
        chk("rr_grant_count_ok", 32'(glog_g.size() >= 5), 32'h1);
        for (int i = 0; i < 5; i++) begin
            if (i < glog_g.size()) begin
                chk("rr_grant_order", 32'(glog_g[i]), 32'(1 << (i % NREQ)));
                if (i > 0) chk("rr_grant_spacing", 32'(glog_c[i] - glog_c[i-1]), 32'(EVAL_LAT + 2));
            end
        end

        // Backpressure: result must hold, nothing else accepted.
        rand_data();
        drive(4'b1111, 4'b0000, EVAL_LAT + 12);
        drive(4'b0000, 4'b1111, 3);

        // Stray handshakes in IDLE and from non-owners in RESP.
        drive(4'b0000, 4'b1111, 4);
        rand_data();
        drive(4'b0010, 4'b1101, 1);
        drive(4'b0000, 4'b1101, EVAL_LAT + 6);
        drive(4'b0000, 4'b0010, 3);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            rand_data();
            if ($urandom_range(0, 299) == 0) begin
                pulse_reset();
            end else begin
                drive(NREQ'($urandom),
                      ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom), 1);
            end
        end

        drive('0, '1, EVAL_LAT + 6);
        chk("drain_empty", 32'(sbq.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cmb_sched.md
CMB_SCHED -- requirements
Module: cmb_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the evaluator; legal range 2..8.
REQ-002 Parameter EVAL_LAT, default 1: cycles from a registered eval_in change to a valid eval_out; legal range 1..15, 0 illegal.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  NREQ  per-requester request present.
REQ-006 req_data  input  NREQ*16  per-requester 16-bit operand; slice i is bits [16i+15:16i].
REQ-007 req_ready  output  NREQ  per-requester accept strobe; one-hot or zero.
REQ-008 rsp_valid  output  NREQ  per-requester result present; one-hot or zero.
REQ-009 rsp_data  output  4  result of the current transaction; meaningful only while a rsp_valid bit is high.
REQ-010 rsp_ready  input  NREQ  per-requester result consumed.
REQ-011 eval_in  output  16  registered operand driven to the shared combinational evaluator.
REQ-012 eval_out  input  4  evaluator result.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 States:
- IDLE: no transaction in flight.
- WAIT: operand issued, counting down evaluator latency.
- RESP: result held and presented to the owner.
REQ-015 Only one transaction is in flight at a time.
REQ-016 In IDLE, req_ready is asserted combinationally for exactly one winner when any req_valid bit is high; otherwise req_ready is all zeros.
REQ-017 Winner selection is round-robin: search starts at pointer ptr and wraps modulo NREQ.
REQ-018 On acceptance at cycle T:
- eval_in <= winner's req_data
- owner <= winner index
- cnt <= EVAL_LAT
- ptr <= (winner+1) mod NREQ
- state <= WAIT
REQ-019 In WAIT, cnt decrements each cycle. When cnt==1, eval_out is captured into the result register and state becomes RESP. WAIT therefore lasts exactly EVAL_LAT cycles.
REQ-020 In RESP, rsp_valid[owner]=1 and rsp_data=result from cycle T+EVAL_LAT+1; both hold until rsp_ready[owner]=1. On that cycle the state returns to IDLE.
REQ-021 eval_in holds its value from acceptance until the next acceptance; it never changes in WAIT or RESP.
REQ-022 rsp_ready bits of non-owners are ignored, and rsp_ready while no rsp_valid is high is ignored.
REQ-023 req_valid is sampled only in IDLE. A requester may drop req_valid before it is accepted without any effect.
REQ-024 No request is accepted in the same cycle as a response handshake. Minimum spacing between acceptances is EVAL_LAT+2 cycles.
REQ-025 ptr changes only on acceptance. A requester that keeps req_valid high is served within NREQ transactions.

Reset
REQ-026 While rst_n=0:
- state=IDLE, ptr=0, owner=0, cnt=0
- eval_in=16'h0000, result=4'h0
- req_ready=0, rsp_valid=0, busy=0
REQ-027 Reset asserted in WAIT or RESP drops the in-flight transaction with no response. After release, arbitration restarts at requester 0.

Structure
REQ-028 Shared package cmb_sched_pkg holds:
- state enum (IDLE, WAIT, RESP)
- DATA_W=16, RES_W=4
- a function returning the counter width clog2(EVAL_LAT+1)
REQ-029 The round-robin selector is a sub-module, cmb_rr_arb:
- inputs: request vector, ptr
- outputs: one-hot grant, grant index
- purely combinational
REQ-030 The evaluator is external to this block. Target size for this block plus cmb_rr_arb is 150-300 lines of RTL.

Verification
Bench evaluator model: eval_out = eval_in[3:0], delayed EVAL_LAT cycles.
REQ-031 Single request: NREQ=4, EVAL_LAT=1; req_valid=4'b0100, req_data[2]=16'hABC5 at T.
- req_ready=4'b0100 at T
- eval_in=16'hABC5 at T+1
- rsp_valid=4'b0100 and rsp_data=4'h5 at T+2
- rsp_ready[2] at T+2 -> IDLE at T+3
REQ-032 Round-robin: all four requesters held valid, rsp_ready tied high -> grant order 0,1,2,3,0, one grant every 3 cycles.
REQ-033 Latency sweep: EVAL_LAT=5, one request at T -> rsp_valid first high at T+6; eval_in stable from T+1 to T+6.
REQ-034 Backpressure: rsp_ready held low 10 cycles while req_valid=4'b1111.
- rsp_valid and rsp_data hold
- req_ready stays 0
- busy stays 1
REQ-035 Reset mid-operation: rst_n pulsed low in WAIT.
- all outputs zero immediately (asynchronous)
- no rsp_valid after release
- next grant goes to requester 0 when req_valid=4'b0001
REQ-036 Stray handshakes: rsp_ready=4'b1111 in IDLE, and rsp_ready from a non-owner in RESP -> no state change and no lost response.
